// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the write-back port arbiter.
//   XLEN_DEF / REGSEL_DEF : default data and register-index widths
//   PERF_W                : width of the contention counter
//   rr_next(g, n)         : modulo-n successor of g, used to advance the
//                           round-robin pointer past the last winner
package wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REGSEL_DEF = 5;
    localparam int PERF_W     = 16;

    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// rr_pick -- combinational rotating-priority picker.
//   req_i     : eligible request vector
//   ptr_i     : index of the highest-priority requester
//   gnt_oh_o  : one-hot grant (all zero when nothing is eligible)
//   gnt_idx_o : binary index of the granted requester
//   gnt_any_o : some requester was granted
module rr_pick
    import wb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_oh_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_any_o
);

    // Walk the requesters starting at ptr and stop at the first one set.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any_o) begin
                idx = (int'(ptr_i) + k) % NREQ;
                if (req_i[PTR_W'(idx)]) begin
                    gnt_any_o               = 1'b1;
                    gnt_oh_o[PTR_W'(idx)]   = 1'b1;
                    gnt_idx_o               = PTR_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter -- round-robin arbiter for the shared register-file write port
// and scoreboard release strobe.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is combinational)
//   req_rd, req_data  : per-requester destination register and write data
//   we, rdwbs, wdata  : registered write port, one cycle after the grant
//   perf_wait         : saturating count of cycles with a refused request
// Build option WB_ARB_X0_FILTER_EN: requests to x0 are acknowledged at once
// without arbitrating, writing, moving the pointer or counting contention.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int XLEN   = XLEN_DEF,
    parameter int REGSEL = REGSEL_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*REGSEL-1:0] req_rd,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   we,
    output logic [REGSEL-1:0]      rdwbs,
    output logic [XLEN-1:0]        wdata,
    output logic [PERF_W-1:0]      perf_wait
);

    localparam int PTR_W = $clog2(NREQ);

    logic [REGSEL-1:0] rd_arr   [NREQ];
    logic [XLEN-1:0]   data_arr [NREQ];
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   x0_ack;
    logic [NREQ-1:0]   gnt_oh;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              grant;
    logic [3:0]        n_elig;
    logic              contend;

    logic [PTR_W-1:0]  ptr_q,   ptr_d;
    logic              we_q,    we_d;
    logic [REGSEL-1:0] rdwbs_q, rdwbs_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [PERF_W-1:0] perf_q,  perf_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rd_arr[i]   = req_rd[i*REGSEL +: REGSEL];
            data_arr[i] = req_data[i*XLEN +: XLEN];
        end
    end

`ifdef WB_ARB_X0_FILTER_EN
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]   = req_valid[i] && (rd_arr[i] != '0);
            x0_ack[i] = req_valid[i] && (rd_arr[i] == '0);
        end
    end
`else
    assign elig   = req_valid;
    assign x0_ack = '0;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i     (elig),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // Nothing is accepted in a reset cycle, so the requester keeps it pending.
    assign grant     = gnt_any && !rst;
    assign req_ready = rst ? '0 : (gnt_oh | x0_ack);

    always_comb begin
        n_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            n_elig = n_elig + 4'(elig[i]);
        end
    end
    assign contend = (n_elig > 4'd1);

    always_comb begin
        ptr_d   = ptr_q;
        we_d    = grant;
        rdwbs_d = rdwbs_q;
        wdata_d = wdata_q;
        perf_d  = perf_q;
        if (grant) begin
            ptr_d   = PTR_W'(rr_next(int'(gnt_idx), NREQ));
            rdwbs_d = rd_arr[gnt_idx];
            wdata_d = data_arr[gnt_idx];
        end
        if (contend && (perf_q != '1)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            rdwbs_q <= '0;
            wdata_q <= '0;
            perf_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            rdwbs_q <= rdwbs_d;
            wdata_q <= wdata_d;
            perf_q  <= perf_d;
        end
    end

    assign we        = we_q;
    assign rdwbs     = rdwbs_q;
    assign wdata     = wdata_q;
    assign perf_wait = perf_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [14:0]  req_rd;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         we;
    logic [4:0]   rdwbs;
    logic [31:0]  wdata;
    logic [15:0]  perf_wait;

    logic [4:0]   tb_rd   [3];
    logic [31:0]  tb_data [3];

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    assign req_rd   = {tb_rd[2], tb_rd[1], tb_rd[0]};
    assign req_data = {tb_data[2], tb_data[1], tb_data[0]};

    wb_arbiter #(.NREQ(3), .XLEN(32), .REGSEL(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .rdwbs     (rdwbs),
        .wdata     (wdata),
        .perf_wait (perf_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs applied in the low phase, ready checked, expected
    // write queued; returns at the next negedge with registered outputs updated.
    task automatic cyc(input logic [2:0] v, input logic [2:0] exp_rdy, input int wr_idx);
        req_valid = v;
        #1;
        chk("req_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
        if (wr_idx >= 0) exp_q.push_back({tb_rd[wr_idx], tb_data[wr_idx]});
        @(negedge clk);
    endtask

    // Monitor: every presented write is matched against the queue head.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", {63'd0, we}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdwbs", {59'd0, rdwbs}, {59'd0, e.rd});
                    chk("wdata", {32'd0, wdata}, {32'd0, e.data});
                end
            end
        end
    end

    initial begin
        int g;
        rst        = 1'b1;
        req_valid  = 3'b000;
        tb_rd[0]   = 5'd1;
        tb_rd[1]   = 5'd2;
        tb_rd[2]   = 5'd3;
        tb_data[0] = 32'hA0A0_0000;
        tb_data[1] = 32'hB1B1_0001;
        tb_data[2] = 32'hC2C2_0002;
        @(negedge clk);

        // Reset held with all requests valid
        cyc(3'b111, 3'b000, -1);
        cyc(3'b111, 3'b000, -1);
        chk("reset_we", {63'd0, we}, 64'd0);
        chk("reset_perf", {48'd0, perf_wait}, 64'd0);
        chk("reset_rdwbs", {59'd0, rdwbs}, 64'd0);
        rst = 1'b0;

        // Full contention: 0,1,2,0,1,2
        cyc(3'b111, 3'b001, 0);
        cyc(3'b111, 3'b010, 1);
        cyc(3'b111, 3'b100, 2);
        cyc(3'b111, 3'b001, 0);
        cyc(3'b111, 3'b010, 1);
        cyc(3'b111, 3'b100, 2);
        chk("perf_after_6", {48'd0, perf_wait}, 64'd6);

        // Two requesters, pointer continues at 0
        cyc(3'b011, 3'b001, 0);
        cyc(3'b011, 3'b010, 1);
        cyc(3'b011, 3'b001, 0);
        chk("perf_after_9", {48'd0, perf_wait}, 64'd9);

        // Idle: we drops, index/data hold
        cyc(3'b000, 3'b000, -1);
        chk("idle_we", {63'd0, we}, 64'd0);
        chk("idle_rdwbs_hold", {59'd0, rdwbs}, 64'd1);
        chk("idle_wdata_hold", {32'd0, wdata}, 64'hA0A0_0000);

        // Single requester 1, rd=5
        tb_rd[1]   = 5'd5;
        tb_data[1] = 32'hDEAD_BEEF;
        cyc(3'b010, 3'b010, 1);
        chk("single_we", {63'd0, we}, 64'd1);
        chk("single_rdwbs", {59'd0, rdwbs}, 64'd5);
        chk("single_wdata", {32'd0, wdata}, 64'hDEAD_BEEF);
        cyc(3'b000, 3'b000, -1);
        chk("single_we_t2", {63'd0, we}, 64'd0);

        // Continuous single requester: granted every cycle, no contention
        cyc(3'b100, 3'b100, 2);
        cyc(3'b100, 3'b100, 2);
        cyc(3'b100, 3'b100, 2);
        chk("perf_single", {48'd0, perf_wait}, 64'd9);

        // x0 handling: requester 0 rd=0, requester 1 rd=7, pointer at 0
        tb_rd[0] = 5'd0;
        tb_rd[1] = 5'd7;
`ifdef WB_ARB_X0_FILTER_EN
        cyc(3'b011, 3'b011, 1);
        cyc(3'b000, 3'b000, -1);
`else
        cyc(3'b011, 3'b001, 0);
        cyc(3'b010, 3'b010, 1);
`endif
        // Pointer must now be 2 in both builds
        tb_rd[0] = 5'd1;
        cyc(3'b111, 3'b100, 2);
`ifdef WB_ARB_X0_FILTER_EN
        chk("perf_x0", {48'd0, perf_wait}, 64'd10);
`else
        chk("perf_x0", {48'd0, perf_wait}, 64'd11);
`endif

        // Reset while requester 2 would be granted
        cyc(3'b111, 3'b001, 0);
        cyc(3'b110, 3'b010, 1);
        rst = 1'b1;
        cyc(3'b100, 3'b000, -1);
        chk("midrst_we", {63'd0, we}, 64'd0);
        chk("midrst_perf", {48'd0, perf_wait}, 64'd0);
        rst = 1'b0;
        cyc(3'b111, 3'b001, 0);

        // Saturation: contention every cycle
        g = 1;
        for (int i = 0; i < 65533; i++) begin
            cyc(3'b111, 3'(3'b001 << g), g);
            g = (g + 1) % 3;
        end
        chk("perf_fffe", {48'd0, perf_wait}, 64'hFFFE);
        for (int i = 0; i < 7; i++) begin
            cyc(3'b111, 3'(3'b001 << g), g);
            g = (g + 1) % 3;
        end
        chk("perf_sat", {48'd0, perf_wait}, 64'hFFFF);

        cyc(3'b000, 3'b000, -1);
        repeat (2) @(negedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
